// File: rtl/mem_responder.sv
// mem_responder: single-outstanding word memory responder with fixed response latency
//   Optional feature macro: MEM_RESPONDER_CHECK_EN (address alignment/range error reporting)
//   Ports:
//     clk        - sole clock, rising edge
//     reset      - asynchronous active-high reset
//     req_valid  - request present          req_ready - accepting (IDLE only)
//     req_we     - 1 write / 0 read         req_addr  - byte address
//     req_wdata  - write data
//     rsp_valid  - response present         rsp_ready - response taken
//     rsp_rdata  - read data (0 for writes/errors)
//     rsp_err    - address error flag
module mem_responder #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t state, state_nx;
   logic [3:0] cnt;
   logic we_q, err_q, addr_err, accept, enter_resp;
   logic [AW-1:0] idx_q;
   logic [31:0] wdata_q, rdata_q;
   logic [31:0] mem [DEPTH];
   logic t_we, t_err;
   logic [AW-1:0] t_idx;
   logic [31:0] t_wdata;

`ifdef MEM_RESPONDER_CHECK_EN
   assign addr_err = (|req_addr[1:0]) || (|req_addr[31:AW+2]);
`else
   logic unused_addr;
   assign unused_addr = ^{req_addr[1:0], req_addr[31:AW+2]};
   assign addr_err = 1'b0;
`endif

   assign req_ready = state == IDLE;
   assign rsp_valid = state == RESP;
   assign rsp_rdata = rsp_valid ? rdata_q : '0;
   assign rsp_err   = rsp_valid & err_q;
   assign accept    = req_ready & req_valid;

   // With zero latency the RESP entry coincides with acceptance, so the
   // transaction fields come straight from the request inputs that cycle.
   assign t_we    = req_ready ? req_we : we_q;
   assign t_err   = req_ready ? addr_err : err_q;
   assign t_idx   = req_ready ? req_addr[AW+1:2] : idx_q;
   assign t_wdata = req_ready ? req_wdata : wdata_q;

   always_comb begin
      state_nx = state;
      if (state == IDLE) begin
         if (req_valid) state_nx = (LATENCY == 0) ? RESP : WAIT;
      end else if (state == WAIT) begin
         if (cnt == 4'd1) state_nx = RESP;
      end else if (rsp_ready) begin
         state_nx = IDLE;
      end
      enter_resp = (state_nx == RESP) && (state != RESP);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            we_q    <= req_we;
            err_q   <= addr_err;
            idx_q   <= req_addr[AW+1:2];
            wdata_q <= req_wdata;
            cnt     <= 4'(LATENCY);
         end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
         end
         if (enter_resp) rdata_q <= (t_we || t_err) ? '0 : mem[t_idx];
      end
   end

   // Storage has no reset; a reset in WAIT forces IDLE so the commit never fires.
   always_ff @(posedge clk) begin
      if (enter_resp && t_we && !t_err) mem[t_idx] <= t_wdata;
   end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the number of 32-bit words stored (power of two, at least 2).
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the number of wait cycles between request acceptance and response (0 to 15).
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1  initiator presents a request.
REQ-006 req_ready  out  1  responder can accept a request this cycle.
REQ-007 req_we  in  1  1 = write, 0 = read.
REQ-008 req_addr  in  32  byte address; word index = req_addr[log2(DEPTH)+1:2].
REQ-009 req_wdata  in  32  write data.
REQ-010 rsp_valid  out  1  response is available.
REQ-011 rsp_ready  in  1  initiator accepts the response.
REQ-012 rsp_rdata  out  32  read data; 0 for write responses.
REQ-013 rsp_err  out  1  error flag (see Configuration).

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-015 req_ready SHALL be 1 only in IDLE, as a registered state decode with no combinational path from req_valid.
- A request is accepted on an edge where req_valid and req_ready are both 1.
- On acceptance the block SHALL capture req_we, the word index and req_wdata.
REQ-016 After acceptance, the FSM SHALL go to WAIT and load a down-counter with LATENCY when LATENCY>0, and go directly to RESP when LATENCY=0.
REQ-017 In WAIT, the counter SHALL decrement each cycle; the FSM SHALL go to RESP on the edge where the counter is 1.
- Accept-to-rsp_valid latency is therefore LATENCY+1 cycles.
REQ-018 Read data SHALL be sampled from storage on the edge entering RESP and held stable in rsp_rdata while in RESP.
REQ-019 A write SHALL commit to storage on the edge entering RESP, so that a read issued after a write's response returns the new data.
REQ-020 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_err SHALL stay stable until rsp_ready=1.
- On the rsp_valid and rsp_ready handshake edge, the FSM SHALL return to IDLE.
REQ-021 A new request SHALL NOT be accepted in the same cycle as a response handshake; at most one transaction is outstanding.
REQ-022 Outside RESP, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-023 req_valid deasserted before acceptance SHALL have no effect, and request inputs SHALL be ignored in WAIT and RESP.

Reset
REQ-024 Asserting reset SHALL immediately force IDLE, counter=0, req_ready=1 (after release), rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-025 Reset during WAIT SHALL abort the transaction, and an uncommitted write SHALL NOT modify storage.
REQ-026 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-027 With macro MEM_RESPONDER_CHECK_EN defined, a request with req_addr[1:0]!=0 or req_addr >= 4*DEPTH SHALL still complete with normal latency, with rsp_err=1 and rsp_rdata=0, and SHALL NOT write storage.
REQ-028 With MEM_RESPONDER_CHECK_EN undefined, req_addr[1:0] and the upper address bits SHALL be ignored (the address wraps modulo DEPTH), and rsp_err SHALL be tied to 0.

Verification
REQ-029 Basic write then read, LATENCY=2:
- Write addr 0x10, data 0xDEADBEEF; rsp_valid asserts 3 cycles after acceptance, with rsp_rdata=0.
- Read addr 0x10; rsp_rdata=0xDEADBEEF after 3 cycles.
REQ-030 Backpressure: hold rsp_ready=0 for 5 cycles in RESP.
- rsp_valid stays 1 and rsp_rdata stays unchanged; req_ready stays 0.
- IDLE is reached one cycle after rsp_ready=1.
REQ-031 LATENCY=0 instance: read addr 0x0 accepted at cycle N.
- rsp_valid=1 at cycle N+1.
- Back-to-back requests complete every 2 cycles when rsp_ready=1.
REQ-032 Reset in WAIT: assert reset one cycle after accepting a write of 0x12345678 to addr 0x20.
- Outputs return to reset values immediately.
- A subsequent read of 0x20 returns its prior value.
REQ-033 With MEM_RESPONDER_CHECK_EN, DEPTH=64:
- Write addr 0x102 gives rsp_err=1, no write.
- Read addr 0x100 gives rsp_err=1, rsp_rdata=0.
- Without the macro, write addr 0x100 lands in word 0.
